// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and reset constants.
// The FETCH_MISALIGN_TRAP_EN macro adds the TRAP state for misaligned redirects.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_TRAP  = 2'd2
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1
    } fetch_state_t;
`endif

endpackage

// File: rtl/pc_reg.sv
// Program counter register and next-PC selection (sequential vs redirect target).
// With FETCH_MISALIGN_TRAP_EN a misaligned redirect holds the PC and flags the hit.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_retire,
    input  logic        i_pc_src,
    input  logic [31:0] i_pc_target,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        o_misalign_hit,
`endif
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_target_masked;

    assign w_target_masked = i_pc_target & 32'hFFFF_FFFC;
    assign o_pc_plus4      = r_pc + 32'd4;
    assign o_pc            = r_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign o_misalign_hit = i_retire && i_pc_src && (i_pc_target[1:0] != 2'b00);

    always_comb begin
        w_pc_next = r_pc;
        if (i_retire) begin
            if (!i_pc_src)
                w_pc_next = o_pc_plus4;
            else if (!o_misalign_hit)
                w_pc_next = w_target_masked;
        end
    end
`else
    always_comb begin
        w_pc_next = r_pc;
        if (i_retire)
            w_pc_next = i_pc_src ? w_target_masked : o_pc_plus4;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_pc <= RESET_PC;
        else
            r_pc <= w_pc_next;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests one word at pc, holds it until retired, counts retirements.
// Define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets (adds misalign port).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instret
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic [31:0] r_instret;
    logic        w_retire;
    logic        w_load;

    assign w_retire = (r_state == ST_HOLD) && instr_ready;
    assign w_load   = (r_state == ST_FETCH) && imem_ack;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic w_misalign_hit;
    logic r_misalign;
`endif

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .reset          (reset),
        .i_retire       (w_retire),
        .i_pc_src       (pc_src),
        .i_pc_target    (pc_target),
`ifdef FETCH_MISALIGN_TRAP_EN
        .o_misalign_hit (w_misalign_hit),
`endif
        .o_pc           (pc),
        .o_pc_plus4     (pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_FETCH;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH: if (imem_ack) w_state_next = ST_HOLD;
            ST_HOLD: begin
                if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    w_state_next = w_misalign_hit ? ST_TRAP : ST_FETCH;
`else
                    w_state_next = ST_FETCH;
`endif
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    // The request is suppressed during reset so a stale read never starts.
    always_comb begin
        imem_req  = (r_state == ST_FETCH) && !reset;
        imem_addr = pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_instret     <= 32'd0;
        end else begin
            if (w_load) begin
                r_instr       <= imem_rdata;
                r_instr_valid <= 1'b1;
            end else if (w_retire) begin
                r_instr_valid <= 1'b0;
            end
            if (w_retire)
                r_instret <= r_instret + 32'd1;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset)
            r_misalign <= 1'b0;
        else if (w_misalign_hit)
            r_misalign <= 1'b1;
    end

    assign misalign = r_misalign;
`endif

    assign instr       = r_instr;
    assign op          = r_instr[6:0];
    assign instr_valid = r_instr_valid;
    assign instret     = r_instret;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  32  read address, equal to pc.
REQ-006 SHALL have port imem_ack  input  1  read data valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  instruction word.
REQ-008 SHALL have port instr  output  32  held instruction to the decoder.
REQ-009 SHALL have port op  output  7  instr[6:0], the opcode field the main decoder consumes.
REQ-010 SHALL have port instr_valid  output  1  instr holds a fetched instruction.
REQ-011 SHALL have port instr_ready  input  1  the downstream datapath retires instr this cycle.
REQ-012 SHALL have port pc_src  input  1  1 = redirect to pc_target (Branch&Zero or Jump).
REQ-013 SHALL have port pc_target  input  32  branch/jump target.
REQ-014 SHALL have port pc  output  32  address of instr; pc_plus4  output  32  pc+4.
REQ-015 SHALL have port instret  output  32  count of retired instructions.

Function
REQ-016 SHALL implement FSM states FETCH and HOLD (plus TRAP, see REQ-027).
REQ-017 In FETCH: imem_req=1, imem_addr=pc; on imem_ack, instr<=imem_rdata, instr_valid<=1, next state HOLD; without imem_ack, remain in FETCH with all outputs held.
REQ-018 In HOLD: imem_req=0; instr and instr_valid are held until instr_ready=1.
REQ-019 Retire = HOLD & instr_ready: pc<=pc_src ? pc_target : pc+4; instr_valid<=0; instret<=instret+1; next state FETCH.
REQ-020 pc_src and pc_target SHALL be sampled only in the retire cycle; ignored otherwise.
REQ-021 instr_ready while instr_valid=0 SHALL have no effect.
REQ-022 Minimum latency: imem_ack in the same cycle as imem_req yields instr_valid the next cycle; throughput 1 instruction per 2 cycles.
REQ-023 pc+4 and instret SHALL wrap modulo 2^32 (pc 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 pc_plus4 SHALL be combinational pc+4; op SHALL be combinational instr[6:0].

Reset
REQ-025 In a reset cycle: pc<=RESET_PC, instr<=32'h0000_0013 (NOP), instr_valid<=0, instret<=0, state<=FETCH, imem_req=0; reset overrides imem_ack and instr_ready in the same cycle.
REQ-026 Reset mid-transaction SHALL discard any pending read; a late imem_ack in the reset cycle is ignored.

Configuration
REQ-027 With FETCH_MISALIGN_TRAP_EN defined: retire with pc_src=1 and pc_target[1:0]!=0 SHALL leave pc unchanged, still increment instret, assert output misalign (1 bit, sticky) and enter TRAP (imem_req=0, instr_valid=0) until reset.
REQ-028 Without FETCH_MISALIGN_TRAP_EN: no misalign port, no TRAP state; pc_target[1:0] SHALL be forced to 2'b00 on redirect.

Structure
REQ-029 Shared package fetch_pkg SHALL hold the FSM state enum, the NOP constant 32'h0000_0013 and the RESET_PC default.
REQ-030 Sub-module pc_reg SHALL hold the PC register and next-PC mux (pc+4 vs target, masking/trap check); FSM and instret stay in fetch_unit.

Verification
REQ-031 Reset, imem_ack=1 every cycle, instr_ready=1 whenever valid, pc_src=0 -> imem_addr 0,4,8,12 on alternate cycles; instret=3 after third retire.
REQ-032 Retire with pc_src=1, pc_target=32'h0000_0040 -> next imem_addr=32'h40, pc_plus4=32'h44.
REQ-033 imem_ack delayed 3 cycles -> imem_req held 4 cycles, instr_valid rises one cycle after ack; instr_ready held low 5 cycles -> instr and pc stable throughout.
REQ-034 RESET_PC=32'hFFFF_FFFC, sequential retire -> next pc=32'h0000_0000.
REQ-035 Reset asserted in HOLD with instr_ready=1 -> pc=RESET_PC, instr_valid=0, instret=0, instr=32'h13 next cycle.
REQ-036 pc_target=32'h0000_0042 redirect -> with FETCH_MISALIGN_TRAP_EN: misalign=1, imem_req stays 0; without: next imem_addr=32'h40.
